// File: rtl/video_loop_pkg.sv
// Shared constants and write-FSM encoding for the UDP video loopback path.
// Frame geometry defaults live here so every stage agrees on FRAME_PIX.
package video_loop_pkg;

  localparam int unsigned H_ACT_D   = 1280;
  localparam int unsigned V_ACT_D   = 720;
  localparam int unsigned FRAME_PIX = H_ACT_D * V_ACT_D;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BURST = 2'd2,
    ST_FLUSH = 2'd3
  } wr_state_t;

  function automatic int unsigned frame_pix(
    input int unsigned h,
    input int unsigned v
  );
    return h * v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy level.
// clr empties the buffer synchronously; rst does so asynchronously.
module sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (level == LW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (level != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop) begin
        level <= level + 1'b1;
      end else if (do_pop && !do_push) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_frame_wr_ctrl.sv
// Buffers received UDP pixels and writes them to the frame buffer
// in fixed-length bursts, restarting the frame address on vs.
module udp_frame_wr_ctrl
  import video_loop_pkg::*;
#(
  parameter int unsigned H_ACT      = H_ACT_D,
  parameter int unsigned V_ACT      = V_ACT_D,
  parameter int unsigned BURST_LEN  = 32,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned ADDR_W     = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rec_en,
  input  logic [23:0]       rec_data,
  input  logic              vs,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              wr_data_valid,
  output logic              frame_done,
  output logic              overflow,
  output logic [15:0]       drop_cnt
);

  localparam int unsigned FRM = frame_pix(H_ACT, V_ACT);
  localparam int unsigned BW  = $clog2(BURST_LEN);
  localparam int unsigned LW  = $clog2(FIFO_DEPTH + 1);

  if ((FRM % BURST_LEN) != 0) begin : g_bad_frame
    $error("frame size must be a whole number of bursts");
  end
  if (FIFO_DEPTH < 2 * BURST_LEN) begin : g_bad_depth
    $error("FIFO must hold at least two bursts");
  end

  wr_state_t         state;
  wr_state_t         state_nxt;
  logic              restart_pend;
  logic [BW-1:0]     beat;
  logic [LW-1:0]     level;
  logic [23:0]       fifo_dout;
  logic              fifo_full;
  logic              blocked;
  logic              push;
  logic              pop;
  logic              clr;
  logic              last_beat;
  logic [ADDR_W-1:0] addr_inc;
  logic              wrap;

  // A vs in the same cycle already blocks the pixel it arrives with.
  assign blocked   = restart_pend | vs;
  assign push      = rec_en & ~blocked & ~fifo_full;
  assign pop       = (state == ST_BURST);
  assign clr       = (state == ST_FLUSH);
  assign last_beat = pop && (beat == BW'(BURST_LEN - 1));
  assign addr_inc  = wr_addr + ADDR_W'(BURST_LEN);
  assign wrap      = (addr_inc == ADDR_W'(FRM));

  assign wr_req        = (state == ST_REQ);
  assign wr_data_valid = pop;
  assign wr_data       = pop ? fifo_dout : '0;

  sync_fifo #(
    .WIDTH (24),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .din   (rec_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .level (level),
    .full  (fifo_full)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (restart_pend) begin
          state_nxt = ST_FLUSH;
        end else if (level >= LW'(BURST_LEN)) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (wr_ack) state_nxt = ST_BURST;
      end
      ST_BURST: begin
        if (last_beat) begin
          state_nxt = restart_pend ? ST_FLUSH : ST_IDLE;
        end
      end
      ST_FLUSH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      beat         <= '0;
      wr_addr      <= '0;
      frame_done   <= 1'b0;
      overflow     <= 1'b0;
      drop_cnt     <= '0;
      restart_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= last_beat && wrap;
      if (pop) begin
        beat <= last_beat ? '0 : beat + 1'b1;
      end
      if (last_beat) begin
        wr_addr <= wrap ? '0 : addr_inc;
      end
      // Flush absorbs any vs seen in its own cycle.
      if (clr) begin
        wr_addr      <= '0;
        overflow     <= 1'b0;
        drop_cnt     <= '0;
        restart_pend <= 1'b0;
      end else begin
        if (vs) restart_pend <= 1'b1;
        if (rec_en && !blocked && fifo_full) begin
          overflow <= 1'b1;
          if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end

endmodule
